// File: rtl/scanchain_ctrl_multi.sv
// Sequences NUM_CHAINS scan chains in order against a DMA command + word stream; stalls hold all counters and drop scan_se.
// Optional SCAN_CRC_EN adds a CRC-32 over every transferred word (0x10) with a compare register (0x14, STATUS[3]).
module scanchain_ctrl_multi #(
  parameter int                         NUM_CHAINS  = 2,
  parameter int                         DATA_WIDTH  = 64,
  parameter logic [16*NUM_CHAINS-1:0]   CHAIN_WORDS = {16'd0, 16'd0},
  parameter logic [4*NUM_CHAINS-1:0]    CHAIN_PREP  = {4'd0, 4'd2}
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [NUM_CHAINS-1:0]            scan_se,
  output logic                             scan_sd,
  output logic [DATA_WIDTH-1:0]            scan_di,
  input  logic [NUM_CHAINS*DATA_WIDTH-1:0] scan_do,
  input  logic                             ctrl_wen,
  input  logic [5:0]                       ctrl_waddr,
  input  logic [31:0]                      ctrl_wdata,
  input  logic                             ctrl_ren,
  input  logic [5:0]                       ctrl_raddr,
  output logic [31:0]                      ctrl_rdata,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic                             cmd_dir,
  output logic [31:0]                      cmd_count,
  input  logic                             s_in_valid,
  output logic                             s_in_ready,
  input  logic [DATA_WIDTH-1:0]            s_in_data,
  output logic                             m_out_valid,
  input  logic                             m_out_ready,
  output logic [DATA_WIDTH-1:0]            m_out_data,
  output logic                             irq
);

  function automatic logic [31:0] sum_words(input logic [16*NUM_CHAINS-1:0] w);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < NUM_CHAINS; i++) s = s + {16'd0, w[16*i +: 16]};
    return s;
  endfunction

  localparam logic [31:0] TOTAL_WORDS = sum_words(CHAIN_WORDS);
  localparam int          IDXW        = $clog2(NUM_CHAINS + 1);
  localparam logic [IDXW-1:0] END_IDX = IDXW'(NUM_CHAINS);
  localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_SEL  = 3'd2;
  localparam logic [2:0] S_PREP = 3'd3;
  localparam logic [2:0] S_SCAN = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]            state;
  logic [IDXW-1:0]       idx;
  logic [15:0]           word_cnt;
  logic [3:0]            prep_cnt;
  logic                  dir, irq_en, done, aborted, crc_match;
  logic [31:0]           xfer_cnt;
  logic [15:0]           cur_words;
  logic [3:0]            cur_prep;
  logic [DATA_WIDTH-1:0] cur_do;
  logic                  ctrl_wr, start_req, abort_req, busy, beat, last_word, se_on;

  always_comb begin
    cur_words = '0;
    cur_prep  = '0;
    cur_do    = '0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (idx == i[IDXW-1:0]) begin
        cur_words = CHAIN_WORDS[16*i +: 16];
        cur_prep  = CHAIN_PREP[4*i +: 4];
        cur_do    = scan_do[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign ctrl_wr   = ctrl_wen && (ctrl_waddr == 6'h00);
  assign busy      = (state != S_IDLE);
  // START is only honoured when idle, so START+ABORT while idle starts a run.
  assign start_req = ctrl_wr && ctrl_wdata[0] && !busy;
  assign abort_req = ctrl_wr && ctrl_wdata[2] && busy;
  assign beat      = (state == S_SCAN) && (dir ? s_in_valid : m_out_ready);
  assign last_word = (word_cnt == cur_words - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      word_cnt <= '0;
      prep_cnt <= '0;
    end else if (abort_req) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start_req) begin
          state <= S_CMD;
          idx   <= '0;
        end
        S_CMD: if (cmd_ready) state <= S_SEL;
        S_SEL: begin
          if (idx == END_IDX) begin
            state <= S_FIN;
          end else if (cur_words == 16'd0) begin
            idx <= idx + IDX_ONE;
          end else begin
            word_cnt <= '0;
            prep_cnt <= '0;
            state    <= (!dir && cur_prep != 4'd0) ? S_PREP : S_SCAN;
          end
        end
        S_PREP: begin
          if (prep_cnt == cur_prep - 4'd1) state <= S_SCAN;
          else prep_cnt <= prep_cnt + 4'd1;
        end
        S_SCAN: if (beat) begin
          if (last_word) begin
            idx   <= idx + IDX_ONE;
            state <= S_SEL;
          end else begin
            word_cnt <= word_cnt + 16'd1;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir      <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (ctrl_wr && !busy) dir <= ctrl_wdata[1];
      if (ctrl_wr) irq_en <= ctrl_wdata[3];
      if (ctrl_wen && ctrl_waddr == 6'h04) begin
        if (ctrl_wdata[1]) done    <= 1'b0;
        if (ctrl_wdata[2]) aborted <= 1'b0;
      end
      // An aborting beat still completes, so it is counted here unconditionally.
      if (beat && xfer_cnt != 32'hFFFF_FFFF) xfer_cnt <= xfer_cnt + 32'd1;
      if (start_req) begin
        done     <= 1'b0;
        aborted  <= 1'b0;
        xfer_cnt <= '0;
      end
      if (state == S_FIN && !abort_req) done <= 1'b1;
      if (abort_req) begin
        aborted <= 1'b1;
        done    <= 1'b0;
      end
    end
  end

  always_comb begin
    scan_di     = '0;
    m_out_valid = 1'b0;
    m_out_data  = '0;
    s_in_ready  = 1'b0;
    se_on       = 1'b0;
    if (state == S_PREP) begin
      se_on   = 1'b1;
      scan_di = cur_do;
    end else if (state == S_SCAN) begin
      if (dir) begin
        s_in_ready = 1'b1;
        scan_di    = s_in_data;
        se_on      = s_in_valid;
      end else begin
        m_out_valid = 1'b1;
        m_out_data  = cur_do;
        scan_di     = cur_do;
        se_on       = m_out_ready;
      end
    end
    scan_se = '0;
    for (int i = 0; i < NUM_CHAINS; i++) scan_se[i] = se_on && (idx == i[IDXW-1:0]);
  end

  assign scan_sd   = dir;
  assign cmd_valid = (state == S_CMD);
  assign cmd_dir   = dir;
  assign cmd_count = TOTAL_WORDS;
  assign irq       = done & irq_en;

`ifdef SCAN_CRC_EN
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DATA_WIDTH-1:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      r = r ^ {d[8*b +: 8], 24'd0};
      for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
    end
    return r;
  endfunction

  logic [31:0] crc, crc_ref;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc     <= 32'hFFFF_FFFF;
      crc_ref <= '0;
    end else begin
      if (start_req) crc <= 32'hFFFF_FFFF;
      else if (beat) crc <= crc_step(crc, dir ? s_in_data : cur_do);
      if (ctrl_wen && ctrl_waddr == 6'h14) crc_ref <= ctrl_wdata;
    end
  end

  assign crc_match = (crc == crc_ref);
`else
  logic wdata_unused;
  assign wdata_unused = ^ctrl_wdata[31:4];
  assign crc_match    = 1'b0;
`endif

  always_comb begin
    ctrl_rdata = '0;
    if (ctrl_ren) begin
      case (ctrl_raddr)
        6'h00:   ctrl_rdata = {28'd0, irq_en, 1'b0, dir, 1'b0};
        6'h04:   ctrl_rdata = {28'd0, crc_match, aborted, done, busy};
        6'h08:   ctrl_rdata = xfer_cnt;
        6'h0C:   ctrl_rdata = TOTAL_WORDS;
`ifdef SCAN_CRC_EN
        6'h10:   ctrl_rdata = crc;
        6'h14:   ctrl_rdata = crc_ref;
`endif
        default: ctrl_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_scanchain_ctrl_multi.sv
// Directed bench: dut (chains {4,3}, prep {2,0}) and dut2 (chains {5,0}) with a shifting-chain model.
module tb_scanchain_ctrl_multi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   scan_se, scan_se2;
  logic         scan_sd, scan_sd2;
  logic [63:0]  scan_di, scan_di2;
  logic [127:0] scan_do, scan_do2;
  logic         ctrl_wen, ctrl_wen2, ctrl_ren;
  logic [5:0]   ctrl_waddr, ctrl_raddr;
  logic [31:0]  ctrl_wdata, ctrl_rdata, ctrl_rdata2;
  logic         cmd_valid, cmd_valid2, cmd_ready, cmd_dir, cmd_dir2;
  logic [31:0]  cmd_count, cmd_count2;
  logic         s_in_valid, s_in_ready, s_in_ready2;
  logic [63:0]  s_in_data;
  logic         m_out_valid, m_out_valid2, m_out_ready;
  logic [63:0]  m_out_data, m_out_data2;
  logic         irq, irq2;

  logic [31:0] sh0, sh1;
  int          src_idx;
  logic        tog, rdy_mode, src_en;

  assign scan_do     = {32'h2, sh1, 32'h1, sh0};
  assign scan_do2    = {64'hC1, 64'hC0};
  assign m_out_ready = rdy_mode ? tog : 1'b1;
  assign s_in_valid  = src_en && (src_idx < 7);
  assign s_in_data   = 64'(src_idx) + 64'd1;

  scanchain_ctrl_multi #(.NUM_CHAINS(2), .DATA_WIDTH(64),
    .CHAIN_WORDS({16'd4, 16'd3}), .CHAIN_PREP({4'd2, 4'd0})) u_dut (
    .clk(clk), .rst(rst), .scan_se(scan_se), .scan_sd(scan_sd), .scan_di(scan_di), .scan_do(scan_do),
    .ctrl_wen(ctrl_wen), .ctrl_waddr(ctrl_waddr), .ctrl_wdata(ctrl_wdata),
    .ctrl_ren(ctrl_ren), .ctrl_raddr(ctrl_raddr), .ctrl_rdata(ctrl_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
    .s_in_valid(s_in_valid), .s_in_ready(s_in_ready), .s_in_data(s_in_data),
    .m_out_valid(m_out_valid), .m_out_ready(m_out_ready), .m_out_data(m_out_data), .irq(irq));

  scanchain_ctrl_multi #(.NUM_CHAINS(2), .DATA_WIDTH(64),
    .CHAIN_WORDS({16'd5, 16'd0}), .CHAIN_PREP({4'd0, 4'd0})) u_dut2 (
    .clk(clk), .rst(rst), .scan_se(scan_se2), .scan_sd(scan_sd2), .scan_di(scan_di2), .scan_do(scan_do2),
    .ctrl_wen(ctrl_wen2), .ctrl_waddr(ctrl_waddr), .ctrl_wdata(ctrl_wdata),
    .ctrl_ren(ctrl_ren), .ctrl_raddr(ctrl_raddr), .ctrl_rdata(ctrl_rdata2),
    .cmd_valid(cmd_valid2), .cmd_ready(1'b1), .cmd_dir(cmd_dir2), .cmd_count(cmd_count2),
    .s_in_valid(1'b0), .s_in_ready(s_in_ready2), .s_in_data(64'd0),
    .m_out_valid(m_out_valid2), .m_out_ready(m_out_ready), .m_out_data(m_out_data2), .irq(irq2));

  // Chain model: each chain's visible word advances once per enabled shift.
  always @(posedge clk) begin
    if (rst) begin
      sh0 <= '0; sh1 <= '0; src_idx <= 0; tog <= 1'b1;
    end else begin
      if (scan_se[0]) sh0 <= sh0 + 32'd1;
      if (scan_se[1]) sh1 <= sh1 + 32'd1;
      if (s_in_valid && s_in_ready) src_idx <= src_idx + 1;
      tog <= ~tog;
    end
  end

  logic [63:0] beat_q [32];
  logic [63:0] di_q   [32];
  int nb, nd, se0_n, se1_n, stall_err, nb2, bad2, se2_0, se2_1;

  always @(negedge clk) begin
    if (rst) begin
      nb = 0; nd = 0; se0_n = 0; se1_n = 0; stall_err = 0;
      nb2 = 0; bad2 = 0; se2_0 = 0; se2_1 = 0;
    end else begin
      if (m_out_valid && m_out_ready) begin
        if (nb < 32) beat_q[nb] = m_out_data;
        nb++;
      end
      if (s_in_valid && s_in_ready) begin
        if (nd < 32) di_q[nd] = scan_di;
        nd++;
      end
      if (scan_se[0]) se0_n++;
      if (scan_se[1]) se1_n++;
      if (m_out_valid && !m_out_ready && scan_se != 2'b00) stall_err++;
      if (m_out_valid2 && m_out_ready) begin
        nb2++;
        if (m_out_data2 != 64'hC1) bad2++;
      end
      if (scan_se2[0]) se2_0++;
      if (scan_se2[1]) se2_1++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input bit sel2, input logic [5:0] a, input logic [31:0] d);
    ctrl_waddr = a;
    ctrl_wdata = d;
    if (sel2) ctrl_wen2 = 1'b1;
    else ctrl_wen = 1'b1;
    @(posedge clk); #1;
    ctrl_wen  = 1'b0;
    ctrl_wen2 = 1'b0;
  endtask

  task automatic rd(input bit sel2, input logic [5:0] a, output logic [31:0] d);
    ctrl_raddr = a;
    ctrl_ren   = 1'b1;
    #1;
    d = sel2 ? ctrl_rdata2 : ctrl_rdata;
    ctrl_ren = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Writes CTRL, checks the command offer, then accepts it for one cycle.
  task automatic start1(input logic [31:0] d, input logic exp_dir);
    wr(1'b0, 6'h00, d);
    chk("cmd_valid", cmd_valid, 1'b1);
    chk("cmd_dir", cmd_dir, exp_dir);
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
  endtask

  task automatic wait_idle(input bit sel2, output int cyc);
    logic [31:0] s;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      rd(sel2, 6'h04, s);
    end while (s[0] && cyc < 200);
    chk("busy_timeout", s[0], 1'b0);
  endtask

  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [63:0] w);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int n = 0; n < 64; n++) begin
      fb = r[31] ^ w[(n/8)*8 + 7 - (n%8)];
      r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
    end
    return r;
  endfunction

  logic [63:0] exp_out [7];
  logic [31:0] rv;
  int          cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_out = '{64'h1_0000_0000, 64'h1_0000_0001, 64'h1_0000_0002,
                64'h2_0000_0002, 64'h2_0000_0003, 64'h2_0000_0004, 64'h2_0000_0005};
    ctrl_wen = 0; ctrl_wen2 = 0; ctrl_ren = 0; ctrl_waddr = 0; ctrl_raddr = 0; ctrl_wdata = 0;
    cmd_ready = 0; rdy_mode = 0; src_en = 0;
    do_reset();

    // reset state
    chk("rst_se", scan_se, 2'b00);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_m_out_valid", m_out_valid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("cmd_count", cmd_count, 32'd7);
    rd(0, 6'h04, rv); chk("rst_status", rv, 32'h0);
    rd(0, 6'h08, rv); chk("rst_xfer", rv, 32'h0);
    rd(0, 6'h0C, rv); chk("total_words", rv, 32'd7);
    rd(0, 6'h00, rv); chk("rst_ctrl", rv, 32'h0);
    rd(0, 6'h18, rv); chk("unmapped", rv, 32'h0);

    // scan-out, sink always ready
    start1(32'h1, 1'b0);
    wait_idle(0, cyc);
    chk("so_cycles", cyc, 13);
    chk("so_beats", nb, 7);
    for (int k = 0; k < 7; k++) chk("so_data", beat_q[k], exp_out[k]);
    chk("so_se0", se0_n, 3);
    chk("so_se1", se1_n, 6);
    rd(0, 6'h04, rv); chk("so_status", rv, 32'h2);
    rd(0, 6'h08, rv); chk("so_xfer", rv, 32'd7);
    chk("irq_off", irq, 1'b0);
    wr(0, 6'h00, 32'h8);
    chk("irq_on", irq, 1'b1);
    wr(0, 6'h04, 32'h2);
    rd(0, 6'h04, rv); chk("done_w1c", rv, 32'h0);
    chk("irq_cleared", irq, 1'b0);

    // scan-in, source words 1..7
    do_reset();
    src_en = 1'b1;
    start1(32'h3, 1'b1);
    wait_idle(0, cyc);
    chk("si_words", nd, 7);
    for (int k = 0; k < 7; k++) chk("si_di", di_q[k], 64'(k + 1));
    chk("si_se0", se0_n, 3);
    chk("si_se1", se1_n, 4);
    chk("si_sd", scan_sd, 1'b1);
    rd(0, 6'h08, rv); chk("si_xfer", rv, 32'd7);
`ifdef SCAN_CRC_EN
    begin
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int k = 1; k <= 7; k++) c = crc_model(c, 64'(k));
      rd(0, 6'h10, rv); chk("crc_value", rv, c);
      wr(0, 6'h14, c);
      rd(0, 6'h04, rv); chk("crc_status", rv, 32'hA);
    end
`else
    rd(0, 6'h10, rv); chk("crc_absent", rv, 32'h0);
    wr(0, 6'h14, 32'h1234_5678);
    rd(0, 6'h14, rv); chk("crc_ref_absent", rv, 32'h0);
    rd(0, 6'h04, rv); chk("si_status", rv, 32'h2);
`endif
    src_en = 1'b0;

    // scan-out with sink toggling
    do_reset();
    rdy_mode = 1'b1;
    start1(32'h1, 1'b0);
    wait_idle(0, cyc);
    chk("tg_beats", nb, 7);
    for (int k = 0; k < 7; k++) chk("tg_data", beat_q[k], exp_out[k]);
    chk("tg_stall_se", stall_err, 0);
    chk("tg_se0", se0_n, 3);
    chk("tg_se1", se1_n, 6);
    rd(0, 6'h08, rv); chk("tg_xfer", rv, 32'd7);
    rdy_mode = 1'b0;

    // abort during the second word (that beat completes and counts)
    do_reset();
    start1(32'h1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    wr(0, 6'h00, 32'h4);
    chk("ab_se", scan_se, 2'b00);
    chk("ab_m_out_valid", m_out_valid, 1'b0);
    chk("ab_beats", nb, 2);
    rd(0, 6'h04, rv); chk("ab_status", rv, 32'h4);
    rd(0, 6'h08, rv); chk("ab_xfer", rv, 32'd2);
    start1(32'h5, 1'b0);
    rd(0, 6'h04, rv); chk("restart_status", rv, 32'h1);
    wait_idle(0, cyc);
    rd(0, 6'h04, rv); chk("restart_done", rv, 32'h2);
    rd(0, 6'h08, rv); chk("restart_xfer", rv, 32'd7);
    chk("restart_beats", nb, 9);

    // skipped chain 0; START while busy ignored
    do_reset();
    chk("d2_cmd_count", cmd_count2, 32'd5);
    wr(1, 6'h00, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    wr(1, 6'h00, 32'h1);
    wait_idle(1, cyc);
    chk("d2_cycles", cyc, 5);
    chk("d2_beats", nb2, 5);
    chk("d2_data", bad2, 0);
    chk("d2_se0", se2_0, 0);
    chk("d2_se1", se2_1, 5);
    rd(1, 6'h08, rv); chk("d2_xfer", rv, 32'd5);
    rd(1, 6'h04, rv); chk("d2_status", rv, 32'h2);

    // reset in the middle of SCAN
    do_reset();
    start1(32'h1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_se", scan_se, 2'b00);
    chk("mr_m_out_valid", m_out_valid, 1'b0);
    chk("mr_m_out_data", m_out_data, 64'h0);
    chk("mr_scan_di", scan_di, 64'h0);
    chk("mr_cmd_valid", cmd_valid, 1'b0);
    chk("mr_sd", scan_sd, 1'b0);
    rd(0, 6'h04, rv); chk("mr_status", rv, 32'h0);
    rd(0, 6'h08, rv); chk("mr_xfer", rv, 32'h0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scanchain_ctrl_multi.md
Name: scanchain_ctrl_multi

Overview:
- Multi-chain successor to the single FF/RAM scan controller; sequences up to NUM_CHAINS independent scan chains (FF or memory type) in a fixed order 0..NUM_CHAINS-1.
- Bridges chains to a word-stream DMA engine: one command handshake per transfer, then a data stream in either direction.
- Sits between platform DMA and emulated design, controlled by 32-bit host register bus; adds abort, status, transfer counter and done interrupt.

Parameters:
- NUM_CHAINS, 2, number of chains (1..8).
- DATA_WIDTH, 64, scan/stream word width.
- CHAIN_WORDS, {16'd0,16'd0}, packed 16-bit word count per chain; chain i at bits [16i+15:16i]; 0 = chain skipped.
- CHAIN_PREP, {4'd0,4'd2}, packed 4-bit pre-scan cycles per chain (memory read latency), applied in scan-out only.
- TOTAL_WORDS, sum of CHAIN_WORDS (derived), total words per transfer.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- scan_se  out  NUM_CHAINS  per-chain scan enable, one-hot or zero
- scan_sd  out  1  scan direction (1 = scan-in)
- scan_di  out  DATA_WIDTH  data into selected chain
- scan_do  in  NUM_CHAINS*DATA_WIDTH  per-chain data out, chain i at slice i
- ctrl_wen/ctrl_waddr/ctrl_wdata  in  1/6/32  register write
- ctrl_ren/ctrl_raddr  in  1/6  register read
- ctrl_rdata  out  32  combinational read data
- cmd_valid  out  1  DMA command valid
- cmd_ready  in  1  DMA command accept
- cmd_dir  out  1  1 = DMA reads memory (scan-in)
- cmd_count  out  32  TOTAL_WORDS
- s_in_valid/s_in_ready/s_in_data  in/out/in  1/1/DATA_WIDTH  scan-in words from DMA
- m_out_valid/m_out_ready/m_out_data  out/in/out  1/1/DATA_WIDTH  scan-out words to DMA
- irq  out  1  level, = DONE & IRQ_EN

Behaviour:
- Registers: 0x00 CTRL [0] START (W1, ignored while busy), [1] DIR, [2] ABORT (W1), [3] IRQ_EN; 0x04 STATUS [0] BUSY, [1] DONE (W1C), [2] ABORTED (W1C); 0x08 XFER_CNT (words moved, RO); 0x0C TOTAL_WORDS (RO); others read 0.
- Reset: FSM IDLE, all outputs 0, DIR=0, IRQ_EN=0, status and XFER_CNT cleared.
- FSM: IDLE -START-> CMD (cmd_valid=1, DIR latched) -cmd_ready-> SEL. SEL: if chain idx == NUM_CHAINS -> FIN; if CHAIN_WORDS[idx]==0 -> idx+1, stay SEL; else load counters -> PREP if !DIR && CHAIN_PREP[idx]!=0, else SCAN. PREP: scan_se[idx]=1 for exactly CHAIN_PREP[idx] cycles, no stream beat. SCAN: one word per handshake; on last word idx+1 -> SEL. FIN: set DONE, clear BUSY -> IDLE. START write clears DONE, ABORTED, XFER_CNT.
- SCAN handshake: scan-out m_out_valid=1, m_out_data=scan_do slice idx, scan_se[idx]=m_out_ready. Scan-in s_in_ready=1, scan_di=s_in_data, scan_se[idx]=s_in_valid. FF chain shift fed back: scan-out scan_di=selected scan_do.
- Stall: no beat -> scan_se 0, counters hold. Word counter 16 bits, compare against CHAIN_WORDS-1; XFER_CNT 32-bit saturating.
- SEL/FIN each cost one cycle; chain with N words, P prep takes 1+P+N cycles unstalled.
- ABORT in any non-IDLE state: next cycle IDLE, all se 0, ABORTED=1, DONE=0; pending beat that same cycle is completed and counted. ABORT in IDLE ignored.
- CTRL write with START and ABORT together while idle: START wins.
- TOTAL_WORDS==0: CMD still issued, then SEL..FIN, DONE set.

Optional Feature:
- SCAN_CRC_EN: CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no reflect) over every transferred word, LSB-byte first; cleared on START; readable at 0x10; STATUS[3] = CRC match against value written to 0x14. Without macro: 0x10/0x14 read 0, writes ignored, STATUS[3]=0, no CRC logic.

Test Plan:
- CHAIN_WORDS={4,3}, PREP={2,0}, DIR=0, sinks always ready -> cmd_count=7; chain0 3 words, chain1 2 prep cycles then 4 words; DONE=1, XFER_CNT=7.
- Same, DIR=1, 7 source words 0x1..0x7 -> scan_di sequence 1..7; no prep cycles; se[0] 3 cycles then se[1] 4 cycles.
- Scan-out with m_out_ready toggling 1/0 -> scan_se low on stalled cycles, data order unchanged, XFER_CNT=7.
- ABORT written after 2 words -> IDLE next cycle, ABORTED=1, DONE=0, XFER_CNT=2; new START clears ABORTED, runs full.
- CHAIN_WORDS={5,0} -> chain0 skipped, only se[1] toggles, 5 words; START during busy ignored.
- rst asserted mid-SCAN -> next cycle all outputs 0, STATUS=0; with SCAN_CRC_EN, scan-in of 0x0 single word yields CRC register expected golden value.
